// File: rtl/sparc_exu_alu_sched.sv
// Round-robin scheduler that shares one SPARC EXU ALU between NREQ requesters,
// decodes the winner's opcode into ALU mux controls and registers the result.
module sparc_exu_alu_sched #(
  parameter int NREQ = 4,
  parameter int OPW  = 4
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [NREQ-1:0]      req_ack,
  input  logic [63:0]          alu_result_e,
  output logic                 ecl_alu_out_sel_sum_e_l,
  output logic                 ecl_alu_out_sel_rs3_e_l,
  output logic                 ecl_alu_out_sel_shift_e_l,
  output logic                 ecl_alu_out_sel_logic_e_l,
  output logic                 ecl_alu_log_sel_and_e,
  output logic                 ecl_alu_log_sel_or_e,
  output logic                 ecl_alu_log_sel_xor_e,
  output logic                 ecl_alu_log_sel_move_e,
  output logic                 ecl_alu_cin_e,
  output logic                 ifu_exu_invert_d,
  output logic                 ecl_alu_sethi_inst_e,
  output logic                 ifu_lsu_casa_e,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [1:0]           res_id,
  output logic [63:0]          res_data,
  output logic                 res_err
);

  localparam int IDW = 2;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_AND   = OPW'(2);
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
  localparam logic [OPW-1:0] OP_ANDN  = OPW'(5);
  localparam logic [OPW-1:0] OP_ORN   = OPW'(6);
  localparam logic [OPW-1:0] OP_XNOR  = OPW'(7);
  localparam logic [OPW-1:0] OP_MOV   = OPW'(8);
  localparam logic [OPW-1:0] OP_SETHI = OPW'(9);
  localparam logic [OPW-1:0] OP_SHIFT = OPW'(10);
  localparam logic [OPW-1:0] OP_RS3   = OPW'(11);
  localparam logic [OPW-1:0] OP_CASA  = OPW'(12);

  typedef enum logic {S_EMPTY, S_FULL} st_e;

  st_e              st_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   res_id_q;
  logic [63:0]      res_data_q;
  logic             res_err_q;

  logic             hold;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   scan_idx;
  logic [OPW-1:0]   gnt_op;
  logic             illegal;

  // A full result that the consumer has not taken blocks new grants.
  assign hold = (st_q == S_FULL) && !res_rdy;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + IDW'(k);
      if (!gnt_any && req_vld[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (reset || hold) gnt_any = 1'b0;
  end

  always_comb begin
    req_ack = '0;
    if (gnt_any) req_ack[gnt_idx] = 1'b1;
  end

  assign gnt_op = req_op[gnt_idx*OPW +: OPW];

  always_comb begin
    ecl_alu_out_sel_sum_e_l   = 1'b1;
    ecl_alu_out_sel_rs3_e_l   = 1'b1;
    ecl_alu_out_sel_shift_e_l = 1'b1;
    ecl_alu_out_sel_logic_e_l = 1'b1;
    ecl_alu_log_sel_and_e     = 1'b0;
    ecl_alu_log_sel_or_e      = 1'b0;
    ecl_alu_log_sel_xor_e     = 1'b0;
    ecl_alu_log_sel_move_e    = 1'b0;
    ecl_alu_cin_e             = 1'b0;
    ifu_exu_invert_d          = 1'b0;
    ecl_alu_sethi_inst_e      = 1'b0;
    ifu_lsu_casa_e            = 1'b0;
    illegal                   = 1'b0;
    if (gnt_any) begin
      case (gnt_op)
        OP_ADD:   ecl_alu_out_sel_sum_e_l = 1'b0;
        OP_SUB: begin
          ecl_alu_out_sel_sum_e_l = 1'b0;
          ecl_alu_cin_e           = 1'b1;
          ifu_exu_invert_d        = 1'b1;
        end
        OP_AND: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_and_e     = 1'b1;
        end
        OP_OR: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_or_e      = 1'b1;
        end
        OP_XOR: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_xor_e     = 1'b1;
        end
        OP_ANDN: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_and_e     = 1'b1;
          ifu_exu_invert_d          = 1'b1;
        end
        OP_ORN: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_or_e      = 1'b1;
          ifu_exu_invert_d          = 1'b1;
        end
        OP_XNOR: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_xor_e     = 1'b1;
          ifu_exu_invert_d          = 1'b1;
        end
        OP_MOV: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_move_e    = 1'b1;
        end
        OP_SETHI: begin
          ecl_alu_out_sel_logic_e_l = 1'b0;
          ecl_alu_log_sel_move_e    = 1'b1;
          ecl_alu_sethi_inst_e      = 1'b1;
        end
        OP_SHIFT: ecl_alu_out_sel_shift_e_l = 1'b0;
        OP_RS3:   ecl_alu_out_sel_rs3_e_l   = 1'b0;
        OP_CASA: begin
          ecl_alu_out_sel_sum_e_l = 1'b0;
          ifu_lsu_casa_e          = 1'b1;
        end
        default:  illegal = 1'b1;
      endcase
    end
  end

  // Result stage: a grant always (re)loads, otherwise an accepted result drains.
  always_ff @(posedge rclk) begin
    if (reset) begin
      st_q       <= S_EMPTY;
      ptr_q      <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      case (st_q)
        S_EMPTY: if (gnt_any) st_q <= S_FULL;
        S_FULL:  if (!gnt_any && res_rdy) st_q <= S_EMPTY;
        default: st_q <= S_EMPTY;
      endcase
      if (gnt_any) begin
        ptr_q      <= gnt_idx + IDW'(1);
        res_id_q   <= gnt_idx;
        res_data_q <= illegal ? 64'd0 : alu_result_e;
        res_err_q  <= illegal;
      end
    end
  end

  assign res_vld  = (st_q == S_FULL);
  assign res_id   = res_id_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;

endmodule
